// File: rtl/ula_seq16.sv
// ula_seq16: runs a W-bit operation through an external combinational 4-bit
// ALU slice, one nibble per clock, least significant nibble first.
module ula_seq16 #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [3:0]             op_s,
    input  logic                   op_m,
    input  logic                   op_cin,
    input  logic [4*NIBBLES-1:0]   opa,
    input  logic [4*NIBBLES-1:0]   opb,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   carry,
    output logic                   equal,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic [3:0]             alu_s,
    output logic                   alu_m,
    output logic                   alu_cin,
    input  logic [3:0]             alu_f,
    input  logic                   alu_c_out,
    input  logic                   alu_a_eq_b
);
    localparam int W   = 4 * NIBBLES;
    localparam int KW  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int KW1 = KW + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t         state;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   shadow;
    logic [W-1:0]   shadow_next;
    logic [KW-1:0]  k;
    logic [KW1-1:0] k_next;
    logic           eq_acc;
    logic           last;

    function automatic logic [3:0] nib(input logic [W-1:0] v, input logic [KW1-1:0] idx);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx == KW1'(i)) r = v[4*i +: 4];
        end
        return r;
    endfunction

    // Shadow with the current nibble's slice result merged in.
    always_comb begin
        shadow_next = shadow;
        for (int i = 0; i < NIBBLES; i++) begin
            if (k == KW'(i)) shadow_next[4*i +: 4] = alu_f;
        end
    end

    assign k_next = KW1'(k) + KW1'(1);
    assign last   = (k == KW'(NIBBLES - 1));

    // alu_s/alu_m hold the latched op for the whole RUN; alu_cin doubles as
    // the inter-nibble carry register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            shadow  <= '0;
            k       <= '0;
            eq_acc  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            carry   <= 1'b0;
            equal   <= 1'b0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_s   <= '0;
            alu_m   <= 1'b0;
            alu_cin <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        a_q     <= opa;
                        b_q     <= opb;
                        k       <= '0;
                        eq_acc  <= 1'b1;
                        alu_a   <= opa[3:0];
                        alu_b   <= opb[3:0];
                        alu_s   <= op_s;
                        alu_m   <= op_m;
                        alu_cin <= op_cin;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        alu_a   <= '0;
                        alu_b   <= '0;
                        alu_s   <= '0;
                        alu_m   <= 1'b0;
                        alu_cin <= 1'b0;
                    end else begin
                        shadow <= shadow_next;
                        eq_acc <= eq_acc & alu_a_eq_b;
                        if (last) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            result  <= shadow_next;
                            carry   <= alu_m ? 1'b0 : alu_c_out;
                            equal   <= eq_acc & alu_a_eq_b;
                            alu_a   <= '0;
                            alu_b   <= '0;
                            alu_s   <= '0;
                            alu_m   <= 1'b0;
                            alu_cin <= 1'b0;
                        end else begin
                            k       <= k_next[KW-1:0];
                            alu_a   <= nib(a_q, k_next);
                            alu_b   <= nib(b_q, k_next);
                            alu_cin <= alu_c_out;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ula_seq16.sv
// Bench for ula_seq16 with a behavioural 4-bit slice and a word-level model.
module tb_ula_seq16;
    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic [3:0]   op_s;
    logic         op_m;
    logic         op_cin;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry;
    logic         equal;
    logic [3:0]   alu_a;
    logic [3:0]   alu_b;
    logic [3:0]   alu_s;
    logic         alu_m;
    logic         alu_cin;
    logic [3:0]   alu_f;
    logic         alu_c_out;
    logic         alu_a_eq_b;

    int checks;
    int failures;

    ula_seq16 #(.NIBBLES(NIB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .op_s(op_s), .op_m(op_m), .op_cin(op_cin), .opa(opa), .opb(opb),
        .busy(busy), .done(done), .result(result), .carry(carry), .equal(equal),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cin(alu_cin),
        .alu_f(alu_f), .alu_c_out(alu_c_out), .alu_a_eq_b(alu_a_eq_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slice: m=0 computes A + Y + cin (Y chosen by s), m=1 a logic function.
    logic [3:0] slice_y;
    logic [4:0] slice_sum;
    always_comb begin
        case (alu_s)
            4'b0101: slice_y = alu_b;
            4'b0110: slice_y = ~alu_b;
            4'b1111: slice_y = 4'hF;
            default: slice_y = 4'h0;
        endcase
        slice_sum = {1'b0, alu_a} + {1'b0, slice_y} + {4'b0, alu_cin};
        if (alu_m) begin
            case (alu_s)
                4'b0110: alu_f = alu_a ^ alu_b;
                4'b1011: alu_f = alu_a & alu_b;
                4'b1110: alu_f = alu_a | alu_b;
                4'b0000: alu_f = ~alu_a;
                default: alu_f = alu_a;
            endcase
            alu_c_out = alu_a[3];
        end else begin
            alu_f     = slice_sum[3:0];
            alu_c_out = slice_sum[4];
        end
    end
    assign alu_a_eq_b = (alu_a == alu_b);

    // Word-level reference.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [3:0] s, input logic m, input logic cin,
                                  output logic [W-1:0] r, output logic c, output logic e);
        logic [W-1:0] y;
        logic [W:0]   sum;
        case (s)
            4'b0101: y = b;
            4'b0110: y = ~b;
            4'b1111: y = '1;
            default: y = '0;
        endcase
        sum = {1'b0, a} + {1'b0, y} + {{W{1'b0}}, cin};
        if (m) begin
            case (s)
                4'b0110: r = a ^ b;
                4'b1011: r = a & b;
                4'b1110: r = a | b;
                4'b0000: r = ~a;
                default: r = a;
            endcase
            c = 1'b0;
        end else begin
            r = sum[W-1:0];
            c = sum[W];
        end
        e = (a == b);
    endfunction

    // Carry entering nibble j in arithmetic mode: carry out of the low 4j bits.
    function automatic logic exp_cin(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic [3:0] s, input logic cin, input int j);
        logic [W-1:0] y;
        logic [W:0]   mask;
        logic [W:0]   part;
        case (s)
            4'b0101: y = b;
            4'b0110: y = ~b;
            4'b1111: y = '1;
            default: y = '0;
        endcase
        mask = ({{W{1'b0}}, 1'b1} << (4 * j)) - 1;
        part = ({1'b0, a} & mask) + ({1'b0, y} & mask) + {{W{1'b0}}, cin};
        return part[4*j];
    endfunction

    logic [3:0]   obs_a   [NIB];
    logic [3:0]   obs_b   [NIB];
    logic         obs_cin [NIB];
    int           early_done;
    int           busy_low;
    int           hold_bad;
    logic         obs_done;
    logic         obs_busy;
    logic [W-1:0] obs_res;
    logic         obs_carry;
    logic         obs_equal;

    // Launch one op, scramble the inputs after acceptance, observe each RUN
    // cycle and the cycle where done is due.
    task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [3:0] s, input logic m, input logic cin);
        logic [W-1:0] res_before;
        @(negedge clk);
        opa = a; opb = b; op_s = s; op_m = m; op_cin = cin;
        start = 1'b1; abort = 1'b0;
        res_before = result;
        early_done = 0; busy_low = 0; hold_bad = 0;
        for (int j = 0; j < NIB; j++) begin
            @(negedge clk);
            start = 1'b0;
            opa = W'($urandom); opb = W'($urandom); op_s = 4'($urandom); op_m = 1'($urandom); op_cin = 1'($urandom);
            obs_a[j] = alu_a; obs_b[j] = alu_b; obs_cin[j] = alu_cin;
            if (done) early_done++;
            if (!busy) busy_low++;
            if (result !== res_before) hold_bad++;
        end
        @(negedge clk);
        obs_done = done; obs_busy = busy; obs_res = result; obs_carry = carry; obs_equal = equal;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        op_s = '0; op_m = 1'b0; op_cin = 1'b0; opa = '0; opb = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, result, carry, equal, alu_a, alu_b, alu_s, alu_m, alu_cin} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b done=%b result=%h carry=%b equal=%b alu=%h/%h/%h/%b/%b expected all 0",
                     busy, done, result, carry, equal, alu_a, alu_b, alu_s, alu_m, alu_cin);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add_basic();
        drive_op(16'h00FF, 16'h0001, 4'b0101, 1'b0, 1'b0);
        checks++; if (early_done != 0 || obs_done !== 1'b1) begin failures++; $display("FAIL add_basic_latency got early=%0d done=%b expected 0/1", early_done, obs_done); end
        checks++; if (busy_low != 0 || obs_busy !== 1'b1) begin failures++; $display("FAIL add_basic_busy got low_cycles=%0d busy_in_done=%b expected 0/1", busy_low, obs_busy); end
        checks++; if (obs_res !== 16'h0100) begin failures++; $display("FAIL add_basic_result got %h expected 0100", obs_res); end
        checks++; if ({obs_carry, obs_equal} !== 2'b00) begin failures++; $display("FAIL add_basic_flags got carry=%b equal=%b expected 0 0", obs_carry, obs_equal); end
        checks++; if (hold_bad != 0) begin failures++; $display("FAIL add_basic_hold result changed %0d times during RUN expected 0", hold_bad); end
        @(negedge clk);
        checks++; if ({done, busy, alu_a, alu_b, alu_s, alu_m, alu_cin} !== '0) begin failures++; $display("FAIL add_basic_idle got done=%b busy=%b alu=%h/%h/%h/%b/%b expected 0", done, busy, alu_a, alu_b, alu_s, alu_m, alu_cin); end
    endtask

    task automatic test_add_carry();
        drive_op(16'hFFFF, 16'h0001, 4'b0101, 1'b0, 1'b0);
        checks++; if (obs_res !== 16'h0000 || obs_carry !== 1'b1) begin failures++; $display("FAIL add_carry_result got %h carry=%b expected 0000 carry=1", obs_res, obs_carry); end
        checks++; if ({obs_cin[0], obs_cin[1], obs_cin[2], obs_cin[3]} !== 4'b0111) begin failures++; $display("FAIL add_carry_chain got cin n0..n3=%b%b%b%b expected 0111", obs_cin[0], obs_cin[1], obs_cin[2], obs_cin[3]); end
        checks++; if (obs_equal !== 1'b0) begin failures++; $display("FAIL add_carry_equal got %b expected 0", obs_equal); end
    endtask

    task automatic test_xor_equal();
        drive_op(16'h1234, 16'h1234, 4'b0110, 1'b1, 1'b0);
        checks++; if (obs_res !== 16'h0000) begin failures++; $display("FAIL xor_result got %h expected 0000", obs_res); end
        checks++; if (obs_equal !== 1'b1 || obs_carry !== 1'b0) begin failures++; $display("FAIL xor_flags got equal=%b carry=%b expected 1 0", obs_equal, obs_carry); end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, er;
        logic [3:0]   s;
        logic         m, cin, ec, ee;
        int           nib_bad;
        for (int t = 0; t < 40; t++) begin
            a = W'($urandom); b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
            s = 4'($urandom_range(0, 15)); m = 1'($urandom); cin = 1'($urandom);
            model(a, b, s, m, cin, er, ec, ee);
            drive_op(a, b, s, m, cin);
            checks++; if (obs_done !== 1'b1 || early_done != 0 || busy_low != 0) begin failures++; $display("FAIL rand_timing t=%0d done=%b early=%0d busy_low=%0d expected 1/0/0", t, obs_done, early_done, busy_low); end
            checks++; if ({obs_res, obs_carry, obs_equal} !== {er, ec, ee}) begin failures++; $display("FAIL rand_result t=%0d a=%h b=%h s=%h m=%b cin=%b got %h c=%b e=%b expected %h c=%b e=%b", t, a, b, s, m, cin, obs_res, obs_carry, obs_equal, er, ec, ee); end
            nib_bad = 0;
            for (int j = 0; j < NIB; j++) begin
                if (obs_a[j] !== a[4*j +: 4] || obs_b[j] !== b[4*j +: 4]) nib_bad++;
                if (!m && obs_cin[j] !== exp_cin(a, b, s, cin, j)) nib_bad++;
            end
            checks++; if (nib_bad != 0) begin failures++; $display("FAIL rand_slice_drive t=%0d bad_nibbles=%0d expected 0", t, nib_bad); end
        end
    endtask

    task automatic test_abort();
        logic [W-1:0] er;
        logic         ec, ee;
        int           stray;
        drive_op(16'hABCD, 16'h0000, 4'b1010, 1'b1, 1'b0);
        checks++; if (obs_res !== 16'hABCD) begin failures++; $display("FAIL abort_setup got %h expected abcd", obs_res); end
        @(negedge clk);
        opa = 16'h1111; opb = 16'h2222; op_s = 4'b0101; op_m = 1'b0; op_cin = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || result !== 16'hABCD) begin failures++; $display("FAIL abort_exit got busy=%b done=%b result=%h expected 0 0 abcd", busy, done, result); end
        checks++; if ({alu_a, alu_b, alu_s, alu_m, alu_cin} !== '0) begin failures++; $display("FAIL abort_alu_idle got %h/%h/%h/%b/%b expected 0", alu_a, alu_b, alu_s, alu_m, alu_cin); end
        stray = 0;
        repeat (6) begin @(negedge clk); if (done || result !== 16'hABCD) stray++; end
        checks++; if (stray != 0) begin failures++; $display("FAIL abort_no_done got %0d stray cycles expected 0", stray); end
        // start and abort together in IDLE: the start wins
        model(16'h0F0F, 16'h0101, 4'b0101, 1'b0, 1'b1, er, ec, ee);
        opa = 16'h0F0F; opb = 16'h0101; op_s = 4'b0101; op_m = 1'b0; op_cin = 1'b1; start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL start_with_abort_accept got busy=%b expected 1", busy); end
        repeat (4) @(negedge clk);
        checks++; if (done !== 1'b1 || result !== er || carry !== ec) begin failures++; $display("FAIL start_with_abort_done got done=%b result=%h carry=%b expected 1 %h %b", done, result, carry, er, ec); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] er;
        logic         ec, ee;
        int           stray;
        @(negedge clk);
        opa = 16'h1357; opb = 16'h2468; op_s = 4'b0101; op_m = 1'b0; op_cin = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, result, carry, equal, alu_a, alu_b, alu_s, alu_m, alu_cin} !== '0) begin
            failures++;
            $display("FAIL reset_async got busy=%b done=%b result=%h carry=%b equal=%b alu=%h/%h/%h/%b/%b expected all 0",
                     busy, done, result, carry, equal, alu_a, alu_b, alu_s, alu_m, alu_cin);
        end
        @(negedge clk); rst_n = 1'b1;
        stray = 0;
        repeat (6) begin @(negedge clk); if (done || busy) stray++; end
        checks++; if (stray != 0) begin failures++; $display("FAIL reset_discard got %0d active cycles expected 0", stray); end
        model(16'h7FFF, 16'h0001, 4'b0101, 1'b0, 1'b0, er, ec, ee);
        drive_op(16'h7FFF, 16'h0001, 4'b0101, 1'b0, 1'b0);
        checks++; if (obs_done !== 1'b1 || early_done != 0 || obs_res !== er || obs_carry !== ec) begin failures++; $display("FAIL reset_then_op got done=%b early=%0d result=%h carry=%b expected 1 0 %h %b", obs_done, early_done, obs_res, obs_carry, er, ec); end
    endtask

    task automatic test_back_to_back();
        int           pulses[$];
        int           bad_res;
        int           gap_bad;
        logic [W-1:0] er;
        logic         ec, ee;
        model(16'h1234, 16'h4321, 4'b0101, 1'b0, 1'b0, er, ec, ee);
        @(negedge clk);
        @(negedge clk);
        opa = 16'h1234; opb = 16'h4321; op_s = 4'b0101; op_m = 1'b0; op_cin = 1'b0; start = 1'b1;
        bad_res = 0;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            if (done) begin
                pulses.push_back(c);
                if (result !== er || !busy) bad_res++;
            end
        end
        start = 1'b0;
        checks++; if (pulses.size() != 4) begin failures++; $display("FAIL b2b_pulse_count got %0d expected 4", pulses.size()); end
        checks++; if (pulses.size() == 0 || pulses[0] != 5) begin failures++; $display("FAIL b2b_first_done got cycle %0d expected 5", (pulses.size() == 0) ? -1 : pulses[0]); end
        gap_bad = 0;
        for (int i = 1; i < pulses.size(); i++) if (pulses[i] - pulses[i-1] != 6) gap_bad++;
        checks++; if (gap_bad != 0) begin failures++; $display("FAIL b2b_spacing got %0d gaps not equal to 6 expected 0", gap_bad); end
        checks++; if (bad_res != 0) begin failures++; $display("FAIL b2b_results got %0d bad pulses expected 0", bad_res); end
        repeat (8) @(negedge clk);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_add_basic();
        test_add_carry();
        test_xor_equal();
        test_random();
        test_abort();
        test_reset_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
